// File: rtl/arm_pkg.sv
// Shared register-file constants, sequencer state type and INIT load value.
package arm_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 15;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

    // Value loaded into R[idx] by the post-reset sequencer.
    function automatic logic [31:0] rf_init_value(input int unsigned idx);
        return idx;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, write-back clears, issue wins.
module rf_scoreboard
    import arm_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic                 i_iss_en,
    input  logic [AW-1:0]        i_iss_dest,
    input  logic                 i_wb_en,
    input  logic [AW-1:0]        i_wb_dest,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]    o_rd_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_run && i_iss_en && (32'(i_iss_dest) < NUM_REGS))
            w_set[i_iss_dest] = 1'b1;
        if (i_run && i_wb_en && (32'(i_wb_dest) < NUM_REGS))
            w_clr[i_wb_dest] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clr) | w_set;   // set applied last: the newer producer wins
    end

    always_comb begin
        o_rd_pending = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (i_run && (32'(i_rd_addr[p*AW +: AW]) < NUM_REGS))
                o_rd_pending[p] = r_pending[i_rd_addr[p*AW +: AW]];
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with INIT sequencer and pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb
    import arm_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W,
    parameter  int NUM_REGS = RF_NUM_REGS,
    parameter  int NUM_RD   = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_dest,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_dest,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     ready
);

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     w_idx_nxt;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_run;
    logic              w_wb_ok;
    logic [NUM_RD-1:0] w_sb_pending;
    logic [NUM_RD-1:0] w_bypass_hit;

    assign w_run   = (r_state == RF_RUN);
    assign w_wb_ok = w_run && wb_en && (32'(wb_dest) < NUM_REGS);
    assign ready   = w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            RF_INIT: begin
                w_idx_nxt = r_idx + AW'(1);
                if (r_idx == AW'(NUM_REGS - 1)) begin
                    w_state_nxt = RF_RUN;
                    w_idx_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the storage array has no reset; the INIT sequencer gives it defined contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == RF_INIT)
                r_regs[r_idx] <= DATA_W'(rf_init_value(32'(r_idx)));
            else if (w_wb_ok)
                r_regs[wb_dest] <= wb_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .AW       (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_run        (w_run),
        .i_iss_en     (iss_en),
        .i_iss_dest   (iss_dest),
        .i_wb_en      (wb_en),
        .i_wb_dest    (wb_dest),
        .i_rd_addr    (rd_addr),
        .o_rd_pending (w_sb_pending)
    );

    always_comb begin
        w_bypass_hit = '0;
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_RD; p++)
            w_bypass_hit[p] = w_wb_ok && (rd_addr[p*AW +: AW] == wb_dest);
`endif
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (w_bypass_hit[p])
                rd_data[p*DATA_W +: DATA_W] = wb_data;
            else if (32'(rd_addr[p*AW +: AW]) < NUM_REGS)
                rd_data[p*DATA_W +: DATA_W] = r_regs[rd_addr[p*AW +: AW]];
        end
    end

    // A forwarded result satisfies the consumer even while its pending bit is still set.
    assign rd_pending = w_sb_pending & ~w_bypass_hit;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized self-checking bench for reg_file_sb against an array-based reference model.
module tb_reg_file_sb;

    localparam int NR  = 15;
    localparam int NRD = 2;
    localparam int AW  = 4;
    localparam int DW  = 32;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] EXP_WR_SAME  = 32'hDEADBEEF;
    localparam logic        EXP_CLR_SAME = 1'b0;
`else
    localparam logic [31:0] EXP_WR_SAME  = 32'h3;
    localparam logic        EXP_CLR_SAME = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_pending;
    logic              iss_en = 1'b0;
    logic [AW-1:0]     iss_dest = '0;
    logic              wb_en = 1'b0;
    logic [AW-1:0]     wb_dest = '0;
    logic [DW-1:0]     wb_data = '0;
    logic              ready;

    reg_file_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .iss_en     (iss_en),
        .iss_dest   (iss_dest),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents, which of them are defined, pending bits.
    logic [DW-1:0] m_regs  [NR];
    bit            m_valid [NR];
    bit            m_pend  [NR];
    int            m_init;
    bit            m_ready;
    bit            m_known;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bypass_hit(input int addr);
`ifdef REGFILE_BYPASS_EN
        return m_ready && wb_en && (int'(wb_dest) == addr) && (addr < NR);
`else
        return 1'b0;
`endif
    endfunction

    task automatic sample_checks();
        @(negedge clk);
        if (m_known) begin
            check("ready", ready, m_ready);
            for (int p = 0; p < NRD; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                if (a >= NR) begin
                    check("rd_oob_data", rd_data[p*DW +: DW], 0);
                    check("rd_oob_pend", rd_pending[p], 0);
                end else if (bypass_hit(a)) begin
                    check("rd_byp_data", rd_data[p*DW +: DW], wb_data);
                    check("rd_byp_pend", rd_pending[p], 0);
                end else begin
                    if (m_valid[a])
                        check("rd_data", rd_data[p*DW +: DW], m_regs[a]);
                    check("rd_pend", rd_pending[p], m_ready && m_pend[a]);
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_ready = 1'b0;
            m_init  = 0;
            for (int i = 0; i < NR; i++) begin
                m_pend[i]  = 1'b0;
                m_valid[i] = 1'b0;
            end
        end else if (!m_ready) begin
            m_regs[m_init]  = DW'(m_init);
            m_valid[m_init] = 1'b1;
            m_init++;
            if (m_init == NR) m_ready = 1'b1;
        end else begin
            if (wb_en && int'(wb_dest) < NR) begin
                m_regs[wb_dest] = wb_data;
                m_pend[wb_dest] = 1'b0;
            end
            if (iss_en && int'(iss_dest) < NR)
                m_pend[iss_dest] = 1'b1;
        end
        #1;
    endtask

    task automatic cyc();
        sample_checks();
        advance();
    endtask

    task automatic idle();
        rst    = 1'b0;
        iss_en = 1'b0;
        wb_en  = 1'b0;
    endtask

    // Counts ready-low cycles from the first post-reset cycle; optionally injects a write in one INIT cycle.
    task automatic wait_ready(input string tag, input int inject);
        int n;
        bit seen;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            wb_en   = (i == inject);
            wb_dest = '0;
            wb_data = 32'hFFFF;
            sample_checks();
            seen = ready;
            advance();
            wb_en = 1'b0;
            if (seen) break;
            n++;
        end
        check(tag, n, NR);
    endtask

    initial begin
        m_known = 1'b0;
        m_ready = 1'b0;
        m_init  = 0;
        for (int i = 0; i < NR; i++) begin
            m_pend[i]  = 1'b0;
            m_valid[i] = 1'b0;
        end
        #1;

        // Reset for two cycles, with a blocked write during INIT cycle 3.
        rst = 1'b1;
        advance();
        advance();
        idle();
        wait_ready("init_len", 3);

        for (int a = 0; a < 16; a++) begin
            rd_addr = {4'(15 - a), 4'(a)};
            sample_checks();
            check("init_rd", rd_data[DW-1:0], (a < NR) ? a : 0);
            advance();
        end

        // Write/read on R3.
        rd_addr = {4'd3, 4'd3};
        wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'hDEADBEEF;
        sample_checks();
        check("wr_same", rd_data[DW-1:0], EXP_WR_SAME);
        advance();
        wb_en = 1'b0;
        sample_checks();
        check("wr_next", rd_data[DW-1:0], 32'hDEADBEEF);
        advance();

        // Scoreboard set and clear on R5.
        rd_addr = {4'd0, 4'd5};
        iss_en = 1'b1; iss_dest = 4'd5;
        cyc();
        iss_en = 1'b0;
        sample_checks();
        check("sb_set", rd_pending[0], 1);
        advance();
        wb_en = 1'b1; wb_dest = 4'd5; wb_data = $urandom;
        sample_checks();
        check("sb_clr_same", rd_pending[0], EXP_CLR_SAME);
        advance();
        wb_en = 1'b0;
        sample_checks();
        check("sb_clr_next", rd_pending[0], 0);
        advance();

        // Issue and write-back to the same pending register.
        rd_addr = {4'd7, 4'd7};
        iss_en = 1'b1; iss_dest = 4'd7;
        cyc();
        wb_en = 1'b1; wb_dest = 4'd7; wb_data = 32'h1234_5678;
        cyc();
        idle();
        sample_checks();
        check("coll_pend", rd_pending[0], 1);
        check("coll_data", rd_data[DW-1:0], 32'h1234_5678);
        advance();

        // Reset in the middle of operation.
        rd_addr = {4'd9, 4'd2};
        iss_en = 1'b1; iss_dest = 4'd2;
        cyc();
        iss_en = 1'b0;
        wb_en = 1'b1; wb_dest = 4'd9; wb_data = 32'h55;
        cyc();
        wb_en = 1'b0;
        rst = 1'b1;
        cyc();
        idle();
        wait_ready("rst_len", -1);
        sample_checks();
        check("rst_pend", rd_pending[0], 0);
        check("rst_r9", rd_data[2*DW-1:DW], 9);
        check("rst_r0", 32'(0), 0) ;
        advance();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(199) == 0);
            iss_en   = $urandom_range(1);
            iss_dest = AW'($urandom_range(15));
            wb_en    = $urandom_range(1);
            wb_dest  = ($urandom_range(3) == 0) ? iss_dest : AW'($urandom_range(15));
            wb_data  = $urandom;
            rd_addr  = {AW'($urandom_range(15)), ($urandom_range(2) == 0) ? wb_dest : AW'($urandom_range(15))};
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
